controlador_botoes: RTL and testbench
=====================================

# controlador_botoes

Multi-channel, parametrised button conditioner feeding the game FSM. Each of `N_BOTOES` active-low raw button inputs is synchronised, debounced with a restart-on-bounce counter, and converted into single-cycle press, release, long-press and auto-repeat pulses plus a clean held level. Channels are fully independent and share only the clock and reset.

## Interface
- `N_BOTOES`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 256: consecutive stable samples required to accept a level change; must be ≥ 2.
- `LONG_CYCLES`, 4096: cycles held after the press pulse before the long pulse; must be ≥ 1.
- `REPEAT_CYCLES`, 1024: auto-repeat period after the long pulse; 0 disables repeat.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `b_in`  in  N_BOTOES  raw buttons; 0 = pressed, asynchronous to `clk`.
- `press`  out  N_BOTOES  one-cycle pulse on accepted press.
- `release`  out  N_BOTOES  one-cycle pulse on accepted release.
- `long`  out  N_BOTOES  one-cycle pulse once per press at the long-press threshold.
- `repeat`  out  N_BOTOES  one-cycle periodic pulse while held past the long threshold.
- `held`  out  N_BOTOES  debounced level; 1 from the press pulse until the release pulse.

## Operation
- Per channel: 2-flop synchroniser, reset value 1 (released); `p` = inverted synchronised bit.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE. Debounce counter `dcnt`, hold counter `hcnt`, repeat counter `rcnt`.
- IDLE: if `p`, go to DEB_PRESS with `dcnt`=1.
- DEB_PRESS: if `!p`, go to IDLE and clear `dcnt` (bounce restarts the count). If `p` and `dcnt`==DEBOUNCE_CYCLES-1, go to HELD, pulse `press`, set `held`, clear `hcnt`/`rcnt`. Otherwise increment `dcnt`.
- HELD: if `!p`, go to DEB_RELEASE with `dcnt`=1 and freeze the hold/repeat counters. Otherwise advance `hcnt` until it reaches LONG_CYCLES, then stop; pulse `long` on the cycle `hcnt` reaches LONG_CYCLES. After that, if REPEAT_CYCLES≠0, advance `rcnt` modulo REPEAT_CYCLES and pulse `repeat` on each wrap to 0.
- DEB_RELEASE: if `p`, return to HELD. No new `press`; the counters resume. If `!p` and `dcnt`==DEBOUNCE_CYCLES-1, go to IDLE, pulse `release`, clear `held`. Otherwise increment `dcnt`.
- Counter widths: `$clog2(max+1)` of their terminal values. There is no wrap or overflow; `hcnt` saturates.
- At most one of `press`/`release`/`long`/`repeat` per channel per cycle. Any number of channels may pulse in the same cycle.

## Timing
- All outputs are registered. Reset value of every output, counter and state is 0 / IDLE; synchroniser flops reset to 1.
- Edge 0 is the first edge sampling `b_in`=0. `press` is high for exactly the cycle after edge DEBOUNCE_CYCLES+1, given a stable input. `release` follows the same latency from the first released sample.
- With `press` in cycle t and no release dip: `long` in t+LONG_CYCLES; `repeat` in t+LONG_CYCLES+k·REPEAT_CYCLES for k≥1. Each release-debounce dip delays these by its length.
- Reset mid-operation: abandon state immediately, with no `release` pulse. A button held through reset produces a fresh `press` after full debounce, counted from the first post-reset sampling edge.
- A glitch shorter than DEBOUNCE_CYCLES produces no output.

## Structure
- Package `botoes_pkg`: state enum (IDLE, DEB_PRESS, HELD, DEB_RELEASE) and the width function for the counters.
- Sub-module `canal_botao`: one synchroniser, FSM and counter set, instantiated N_BOTOES times by a generate loop. The top level is wiring only.

## Test plan
Bench parameters: N_BOTOES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=4.
- Clean press on ch0, `b_in`=2'b10 from edge 0, held 10 cycles → `press[0]` high in the cycle after edge 5 only; `held[0]`=1 from then on. Then release → `release[0]` 6 edges after the first released sample, and `held[0]`=0.
- Bounce 0,1,0,0,1 then stable 0 → no pulse until 4 consecutive pressed samples, then a single `press`.
- Held for 40 cycles after `press` at t → `long` at t+16, `repeat` at t+20, t+24, …, t+40. No second `press`.
- 2-cycle release glitch while HELD → no `release`, no `press`, and `long` is delayed by 2 cycles.
- Both channels pressed on the same edge → `press`=2'b11 in one cycle. `rst` asserted mid-HELD → all outputs 0 the next cycle with no `release`, then a fresh `press` after debounce.

Source files
------------

// File: rtl/botoes_pkg.sv
// ----------------------------------------------------------------------------
// botoes_pkg
// Shared definitions for the button conditioner:
//   - estado_t  : per-channel debounce/hold state machine encoding
//   - cnt_width : counter width able to hold values 0..max_val (never < 1 bit)
// ----------------------------------------------------------------------------
package botoes_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } estado_t;

    // A terminal value of 0 still needs one bit so the counter exists.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/canal_botao.sv
// ----------------------------------------------------------------------------
// canal_botao
// One button channel: 2-flop synchroniser, restart-on-bounce debouncer and
// hold/auto-repeat timing. All outputs are registered.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   b_in_i     in   raw button, active low, asynchronous to clk
//   press_o    out  one-cycle pulse on accepted press
//   release_o  out  one-cycle pulse on accepted release
//   long_o     out  one-cycle pulse when the hold time reaches LONG_CYCLES
//   repeat_o   out  one-cycle pulse every REPEAT_CYCLES after the long pulse
//   held_o     out  debounced level, 1 from press pulse until release pulse
// ----------------------------------------------------------------------------
module canal_botao
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int LONG_CYCLES     = 4096,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic b_in_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam int RW = cnt_width((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES);
    localparam logic [RW-1:0] R_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [DW-1:0] D_ONE  = DW'(1);

    logic [1:0]    sync_q;
    estado_t       state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    // One step of the hold/repeat timers, applied on every pressed sample
    // while the button counts as held (including the sample that ends a
    // release dip, so a dip delays the timers by exactly its length).
    logic [HW-1:0] hcnt_step;
    logic [RW-1:0] rcnt_step;
    logic          long_step;
    logic          repeat_step;

    logic p;
    assign p = ~sync_q[1];

    always_comb begin
        hcnt_step   = hcnt_q;
        rcnt_step   = rcnt_q;
        long_step   = 1'b0;
        repeat_step = 1'b0;
        if (hcnt_q != H_LAST) begin
            hcnt_step = hcnt_q + 1'b1;
            long_step = (hcnt_q == H_LAST - 1'b1);
        end else if (REPEAT_CYCLES != 0) begin
            if (rcnt_q == R_LAST) begin
                rcnt_step   = '0;
                repeat_step = 1'b1;
            end else begin
                rcnt_step = rcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = held_q;
        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = DEB_PRESS;
                    dcnt_d  = D_ONE;
                end
            end
            DEB_PRESS: begin
                if (!p) begin
                    // Bounce: the debounce count starts over.
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    rcnt_d  = '0;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    // Timers freeze while the release is being debounced.
                    state_d = DEB_RELEASE;
                    dcnt_d  = D_ONE;
                end else begin
                    hcnt_d   = hcnt_step;
                    rcnt_d   = rcnt_step;
                    long_d   = long_step;
                    repeat_d = repeat_step;
                end
            end
            DEB_RELEASE: begin
                if (p) begin
                    // Short release glitch: back to held, timers resume.
                    state_d  = HELD;
                    dcnt_d   = '0;
                    hcnt_d   = hcnt_step;
                    rcnt_d   = rcnt_step;
                    long_d   = long_step;
                    repeat_d = repeat_step;
                end else if (dcnt_q == D_LAST) begin
                    state_d   = IDLE;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], b_in_i};
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            rcnt_q    <= rcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign held_o    = held_q;

endmodule

// File: rtl/controlador_botoes.sv
// ----------------------------------------------------------------------------
// controlador_botoes
// Multi-channel button conditioner: N_BOTOES independent canal_botao
// instances sharing clock and reset. Wiring only.
//
// Ports (all vectors N_BOTOES wide, bit i = channel i):
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   b_in_i     in   raw buttons, 0 = pressed, asynchronous
//   press_o    out  one-cycle press pulses
//   release_o  out  one-cycle release pulses
//   long_o     out  one-cycle long-press pulses
//   repeat_o   out  one-cycle auto-repeat pulses
//   held_o     out  debounced held levels
// ----------------------------------------------------------------------------
module controlador_botoes
    import botoes_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int LONG_CYCLES     = 4096,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] b_in_i,
    output logic [N_BOTOES-1:0] press_o,
    output logic [N_BOTOES-1:0] release_o,
    output logic [N_BOTOES-1:0] long_o,
    output logic [N_BOTOES-1:0] repeat_o,
    output logic [N_BOTOES-1:0] held_o
);

    for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_canal
        canal_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_canal (
            .clk      (clk),
            .rst      (rst),
            .b_in_i   (b_in_i[gi]),
            .press_o  (press_o[gi]),
            .release_o(release_o[gi]),
            .long_o   (long_o[gi]),
            .repeat_o (repeat_o[gi]),
            .held_o   (held_o[gi])
        );
    end

endmodule

// File: tb/tb_controlador_botoes.sv
// ----------------------------------------------------------------------------
// tb_controlador_botoes
// Two-channel bench (DEBOUNCE=4, LONG=16, REPEAT=4). Each scenario drives
// b_in_i on the falling edge, pushes the pulses it expects (absolute cycle
// number plus pulse vectors) into a scoreboard queue, and tick() pops and
// compares them as the cycles arrive. Any pulse with no matching entry is
// reported as unexpected.
// Cycle numbering: cyc counts rising edges; a value driven at the falling
// edge with cyc == c is first sampled by the edge that makes cyc == c+1.
// ----------------------------------------------------------------------------
module tb_controlador_botoes;

    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int LNG = 16;
    localparam int REP = 4;
    localparam int LAT = DEB + 2;   // drive -> pulse visible

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] b_in_i;
    logic [N-1:0] press_o, release_o, long_o, repeat_o, held_o;

    controlador_botoes #(
        .N_BOTOES       (N),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .b_in_i   (b_in_i),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .held_o   (held_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] lg;
        logic [N-1:0] rp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic push_ev(input int c, input logic [N-1:0] pr, input logic [N-1:0] rl,
                           input logic [N-1:0] lg, input logic [N-1:0] rp);
        exp_t e;
        e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg; e.rp = rp;
        sb.push_back(e);
    endtask

    // Advance one cycle and reconcile DUT pulses against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_total++;
            $display("FAIL missed_event: expected pulses at cyc %0d, now cyc %0d", e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_total++;
            if ({press_o, release_o, long_o, repeat_o} !== {e.pr, e.rl, e.lg, e.rp}) begin
                $display("FAIL event cyc=%0d: got press=%b release=%b long=%b repeat=%b, want press=%b release=%b long=%b repeat=%b",
                         cyc, press_o, release_o, long_o, repeat_o, e.pr, e.rl, e.lg, e.rp);
            end else begin
                n_pass++;
                $display("ok   event cyc=%0d press=%b release=%b long=%b repeat=%b",
                         cyc, press_o, release_o, long_o, repeat_o);
            end
        end else if ((press_o | release_o | long_o | repeat_o) !== '0) begin
            n_total++;
            $display("FAIL unexpected_pulse cyc=%0d: got press=%b release=%b long=%b repeat=%b, want all 0",
                     cyc, press_o, release_o, long_o, repeat_o);
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        b_in_i = '1;
        repeat (3) tick();
        n_total++;
        if (press_o !== '0) $display("FAIL reset_press: got %b want 00", press_o);
        else n_pass++;
        n_total++;
        if (release_o !== '0) $display("FAIL reset_release: got %b want 00", release_o);
        else n_pass++;
        n_total++;
        if (long_o !== '0) $display("FAIL reset_long: got %b want 00", long_o);
        else n_pass++;
        n_total++;
        if (repeat_o !== '0) $display("FAIL reset_repeat: got %b want 00", repeat_o);
        else n_pass++;
        n_total++;
        if (held_o !== '0) $display("FAIL reset_held: got %b want 00", held_o);
        else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        int c, r;
        c = cyc;
        b_in_i = 2'b10;
        push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b00);
        run_to(c + LAT - 1);
        n_total++;
        if (held_o !== 2'b00) $display("FAIL clean_held_before: got %b want 00", held_o);
        else n_pass++;
        tick();
        n_total++;
        if (held_o !== 2'b01) $display("FAIL clean_held_at_press: got %b want 01", held_o);
        else n_pass++;
        run_to(c + 16);
        r = cyc;
        b_in_i = 2'b11;
        push_ev(r + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        run_to(r + LAT - 1);
        n_total++;
        if (held_o !== 2'b01) $display("FAIL clean_held_before_release: got %b want 01", held_o);
        else n_pass++;
        tick();
        n_total++;
        if (held_o !== 2'b00) $display("FAIL clean_held_after_release: got %b want 00", held_o);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (sb.size() != 0) $display("FAIL clean_pending: got %0d pending events want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic pat [5];
        int   c, r;
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        c = cyc;
        for (int j = 0; j < 5; j++) begin
            b_in_i = {1'b1, pat[j]};
            tick();
        end
        b_in_i = 2'b10;
        push_ev(c + 5 + LAT, 2'b01, 2'b00, 2'b00, 2'b00);
        run_to(c + 14);
        r = cyc;
        b_in_i = 2'b11;
        push_ev(r + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        run_to(r + LAT + 4);
        n_total++;
        if (sb.size() != 0) $display("FAIL bounce_pending: got %0d pending events want 0", sb.size());
        else n_pass++;
        n_total++;
        if (held_o !== 2'b00) $display("FAIL bounce_held_end: got %b want 00", held_o);
        else n_pass++;
    endtask

    task automatic test_long_repeat();
        int c, t;
        c = cyc;
        t = c + LAT;
        b_in_i = 2'b10;
        push_ev(t, 2'b01, 2'b00, 2'b00, 2'b00);
        push_ev(t + LNG, 2'b00, 2'b00, 2'b01, 2'b00);
        for (int k = 1; k <= 6; k++) push_ev(t + LNG + k * REP, 2'b00, 2'b00, 2'b00, 2'b01);
        // Released so the first !p sample lands on the would-be t+44 repeat.
        push_ev(t + 41 + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        run_to(t + 30);
        n_total++;
        if (held_o !== 2'b01) $display("FAIL long_held_mid: got %b want 01", held_o);
        else n_pass++;
        run_to(t + 41);
        b_in_i = 2'b11;
        run_to(t + 41 + LAT + 3);
        n_total++;
        if (sb.size() != 0) $display("FAIL long_pending: got %0d pending events want 0", sb.size());
        else n_pass++;
        n_total++;
        if (held_o !== 2'b00) $display("FAIL long_held_end: got %b want 00", held_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int c, t;
        c = cyc;
        t = c + LAT;
        b_in_i = 2'b10;
        push_ev(t, 2'b01, 2'b00, 2'b00, 2'b00);
        push_ev(t + LNG + 2, 2'b00, 2'b00, 2'b01, 2'b00);
        push_ev(t + 19 + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        run_to(t + 5);
        b_in_i = 2'b11;
        run_to(t + 7);
        b_in_i = 2'b10;
        run_to(t + 12);
        n_total++;
        if (held_o !== 2'b01) $display("FAIL glitch_held: got %b want 01", held_o);
        else n_pass++;
        run_to(t + 19);
        b_in_i = 2'b11;
        run_to(t + 19 + LAT + 3);
        n_total++;
        if (sb.size() != 0) $display("FAIL glitch_pending: got %0d pending events want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_both_and_reset();
        int c, c2, r;
        c = cyc;
        b_in_i = 2'b00;
        push_ev(c + LAT, 2'b11, 2'b00, 2'b00, 2'b00);
        run_to(c + 10);
        n_total++;
        if (held_o !== 2'b11) $display("FAIL both_held: got %b want 11", held_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({press_o, release_o, long_o, repeat_o, held_o} !== '0)
            $display("FAIL midreset_outputs: got press=%b release=%b long=%b repeat=%b held=%b want all 0",
                     press_o, release_o, long_o, repeat_o, held_o);
        else n_pass++;
        rst = 1'b0;
        c2 = cyc;
        push_ev(c2 + LAT, 2'b11, 2'b00, 2'b00, 2'b00);
        run_to(c2 + LAT - 1);
        n_total++;
        if (held_o !== 2'b00) $display("FAIL postreset_held_before: got %b want 00", held_o);
        else n_pass++;
        run_to(c2 + LAT + 2);
        n_total++;
        if (held_o !== 2'b11) $display("FAIL postreset_held: got %b want 11", held_o);
        else n_pass++;
        r = cyc;
        b_in_i = 2'b11;
        push_ev(r + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        run_to(r + LAT + 3);
        n_total++;
        if (sb.size() != 0) $display("FAIL both_pending: got %0d pending events want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        rst    = 1'b1;
        b_in_i = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_glitch();
        test_both_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
